// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
// The ovf signal is present only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b processed LSB first, one bit per clock.
// Define SUB_OVF_EN to add the signed overflow flag (ovf).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full subtractor as two cascaded half subtractors; either stage may raise the borrow.
    logic hs1_diff, hs1_borrow, hs2_borrow, bit_diff, bit_borrow;
    always_comb begin
        hs1_diff   = sa_q[0] ^ sb_q[0];
        hs1_borrow = ~sa_q[0] & sb_q[0];
        bit_diff   = hs1_diff ^ br_q;
        hs2_borrow = ~hs1_diff & br_q;
        bit_borrow = hs1_borrow | hs2_borrow;
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SUB_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
                sr_d  = {bit_diff, sr_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = bit_borrow;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                diff_d   = sr_q;
                borrow_d = br_q;
`ifdef SUB_OVF_EN
                ovf_d    = (a_msb_q != b_msb_q) && (sr_q[WIDTH-1] != a_msb_q);
`endif
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
`ifdef SUB_OVF_EN
    assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
// Define SUB_OVF_EN to also check the overflow flag.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] prev_diff;
    logic         prev_borrow;
    logic         prev_ovf;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one subtraction; optionally fires extra start pulses that must be ignored.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tbv, input bit inject);
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ovf;
        int           signed_res;
        int           n;
        int           busy_cnt;
        int           done_cnt;
        int           done_at;

        exp_diff   = W'(int'(ta) - int'(tbv) + 256);
        exp_borrow = (ta < tbv);
        signed_res = int'($signed(ta)) - int'($signed(tbv));
        exp_ovf    = (signed_res > 127) || (signed_res < -128);

        bus.a     = ta;
        bus.b     = tbv;
        bus.start = 1'b1;
        stepCycle();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);

        busy_cnt = int'(bus.busy);
        done_cnt = int'(bus.done);
        checkOutput("hold_diff", 32'(bus.diff), 32'(prev_diff));
        checkOutput("hold_borrow", 32'(bus.borrow_out), 32'(prev_borrow));
`ifdef SUB_OVF_EN
        checkOutput("hold_ovf", 32'(bus.ovf), 32'(prev_ovf));
`endif

        n = 0;
        done_at = 0;
        while (n < 40) begin
            stepCycle();
            n++;
            if (inject && (n == 2 || n == 4 || n == 8)) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            busy_cnt += int'(bus.busy);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = n;
                    checkOutput("diff", 32'(bus.diff), 32'(exp_diff));
                    checkOutput("borrow_out", 32'(bus.borrow_out), 32'(exp_borrow));
`ifdef SUB_OVF_EN
                    checkOutput("ovf", 32'(bus.ovf), 32'(exp_ovf));
`endif
                end
            end
            if (done_at != 0 && n >= done_at + 3) break;
        end

        checkOutput("done_latency", 32'(done_at), 32'(W + 1));
        checkOutput("done_count", 32'(done_cnt), 32'd1);
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(W));
        checkOutput("held_diff", 32'(bus.diff), 32'(exp_diff));
        checkOutput("held_borrow", 32'(bus.borrow_out), 32'(exp_borrow));

        prev_diff   = exp_diff;
        prev_borrow = exp_borrow;
        prev_ovf    = exp_ovf;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_ovf    = 1'b0;

        stepCycle();
        stepCycle();
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_diff", 32'(bus.diff), 32'd0);
        checkOutput("reset_borrow", 32'(bus.borrow_out), 32'd0);
        rst = 1'b0;
        stepCycle();

        applyStimulus(8'd100, 8'd37, 1'b0);
        applyStimulus(8'd5, 8'd10, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'hFF, 1'b0);
        applyStimulus(8'd77, 8'd200, 1'b1);

        // Abort in RUN cycle 4: state and held results must clear, no done afterwards.
        bus.a     = 8'd90;
        bus.b     = 8'd20;
        bus.start = 1'b1;
        stepCycle();
        bus.start = 1'b0;
        repeat (3) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_diff", 32'(bus.diff), 32'd0);
        checkOutput("abort_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SUB_OVF_EN
        checkOutput("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
        begin
            int late_done = 0;
            for (int i = 0; i < 12; i++) begin
                stepCycle();
                late_done += int'(bus.done);
            end
            checkOutput("abort_no_done", 32'(late_done), 32'd0);
        end
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_ovf    = 1'b0;

        applyStimulus(8'd200, 8'd55, 1'b0);

        applyStimulus(8'h80, 8'h01, 1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b0);
        applyStimulus(8'h10, 8'h20, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'(i % 3 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Inverse arithmetic partner to the team's combinational adder cells. Per-bit datapath is a full subtractor built from two half subtractors plus an OR for borrow.
- Used where area matters more than latency. Start/busy/done handshake; result held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge clock; sole clock domain.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request pulse; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepted start.
- b, input, WIDTH, subtrahend; captured on the accepted start.
- busy, output, 1, high while an operation is in progress (RUN state).
- done, output, 1, single-cycle pulse marking a valid result.
- diff, output, WIDTH, result a - b mod 2^WIDTH; held stable between done pulses.
- borrow_out, output, 1, final borrow; 1 when a < b unsigned; held with diff.
- ovf, output, 1, signed overflow flag; exists only with SUB_OVF_EN.

Behaviour:
- Reset: on rst=1 at a clk edge, the following are cleared to 0: state=IDLE, busy, done, diff, borrow_out, ovf, shift registers, borrow flop, bit counter.
- rst has priority over every other input, including mid-RUN. An aborted operation never produces done.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 loads a into shift register SA and b into SB.
  - The borrow flop is cleared, the bit counter is cleared, and the FSM goes to RUN.
  - start=0 stays in IDLE.
- RUN, per cycle:
  - d = SA[0] ^ SB[0] ^ br.
  - br_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br).
  - d is shifted into the MSB of the result shift register. SA and SB shift right by one. The counter increments.
  - After WIDTH bit-cycles the FSM goes to DONE. The counter is $clog2(WIDTH+1) bits and never wraps.
- DONE, for exactly one cycle:
  - done=1.
  - diff is loaded from the result register, and borrow_out is loaded from the final br.
  - The FSM returns to IDLE.
- busy=1 exactly while in RUN.
- Latency: start accepted at edge T, then done=1 in the cycle after edge T+WIDTH+1. With WIDTH=8, done is high 9 cycles after the start edge.
- start while in RUN or DONE is ignored, with no queuing. a and b changes after capture have no effect.
- diff, borrow_out and ovf update only on entry to DONE. They keep their last values through IDLE and RUN of the next operation.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - The ovf port exists.
  - The sign bits of a and b are registered at start.
  - On DONE, ovf = (a_msb != b_msb) && (diff_msb != a_msb).
  - ovf is held with diff and is cleared by rst.
- Undefined: the ovf port and its logic are absent. All other behaviour is unchanged.

Test Plan:
- Basic, borrow clear: rst 2 cycles; start with a=100, b=37 (WIDTH=8) -> busy for 8 cycles; done pulse 9 cycles after the start edge; diff=63, borrow_out=0.
- Underflow: a=5, b=10 -> diff=251 (8'hFB), borrow_out=1; values held after done drops until the next done.
- Boundaries:
  - a=0, b=0 -> diff=0, borrow=0.
  - a=8'hFF, b=8'h00 -> diff=8'hFF, borrow=0.
  - a=8'h00, b=8'hFF -> diff=8'h01, borrow=1.
- Ignored start: start pulses in RUN cycles 3 and 5 and in the DONE cycle, with different a/b -> exactly one done; result matches the first operands; busy never extends.
- Reset mid-operation: rst=1 in RUN cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0; a new start after reset completes correctly with a=200, b=55 -> diff=145.
- SUB_OVF_EN:
  - a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, borrow=0.
  - a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1, borrow=1.
  - a=8'h10, b=8'h20 -> ovf=0.
